// File: rtl/tx_pkg.sv
// tx_pkg: mode encodings and state enum shared by the serializer and the engine FSMs.
package tx_pkg;
  localparam logic [2:0] MODE_IDLE_REL = 3'b000;
  localparam logic [2:0] MODE_SERIAL   = 3'b001;
  localparam logic [2:0] MODE_TBIT     = 3'b011;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SERIAL, ST_TBIT} state_e;
endpackage

// File: rtl/tx_serializer_if.sv
// tx_serializer_if: request and serial-bus bundle between the CCC engine (master) and the serializer (slave).
interface tx_serializer_if;
  logic       i_tx_en;
  logic [2:0] i_tx_mode;
  logic [7:0] i_regf_data;
  logic       i_scl_neg_edge;
  logic       o_sda;
  logic       o_sda_oe;
  logic       o_tx_mode_done;
  logic       o_busy;
  modport master (output i_tx_en, i_tx_mode, i_regf_data, i_scl_neg_edge,
                  input o_sda, o_sda_oe, o_tx_mode_done, o_busy);
  modport slave (input i_tx_en, i_tx_mode, i_regf_data, i_scl_neg_edge,
                 output o_sda, o_sda_oe, o_tx_mode_done, o_busy);
endinterface

// File: rtl/tx_parity.sv
// tx_parity: odd-parity bit of a byte (1 when the popcount is even).
module tx_parity (
  input  logic [7:0] data,
  output logic       parity
);
  assign parity = ~^data;
endmodule

// File: rtl/tx_serializer.sv
// tx_serializer: shifts a register-file byte out MSB first on SCL falling edges, or releases the bus.
// Define TX_SERIALIZER_TBIT_EN to add the parity T-bit mode (otherwise mode 011 is a release).
module tx_serializer
  import tx_pkg::*;
(
  input logic            i_clk,
  input logic            i_rst,
  tx_serializer_if.slave bus
);
  state_e state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] cnt, cnt_n;
  logic sda, sda_n, oe, oe_n, done, done_n;
  logic tbit_go, par;
`ifdef TX_SERIALIZER_TBIT_EN
  logic [7:0] last_byte;
  assign tbit_go = bus.i_tx_mode == MODE_TBIT;
  tx_parity u_parity (.data(last_byte), .parity(par));
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) last_byte <= '0;
    else if (state == ST_LOAD) last_byte <= bus.i_regf_data;
`else
  assign tbit_go = 1'b0;
  assign par = 1'b1;
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= ST_IDLE;
      shift <= '0;
      cnt   <= '0;
      sda   <= 1'b1;
      oe    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      cnt   <= cnt_n;
      sda   <= sda_n;
      oe    <= oe_n;
      done  <= done_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (bus.i_tx_en) state_n = bus.i_tx_mode == MODE_SERIAL ? ST_LOAD : tbit_go ? ST_TBIT : ST_IDLE;
      ST_LOAD:   state_n = ST_SERIAL;
      ST_SERIAL: if (bus.i_scl_neg_edge && cnt == 3'd7) state_n = ST_IDLE;
      default:   if (bus.i_scl_neg_edge) state_n = ST_IDLE;
    endcase
  end
  // sda/oe default to holding so a byte and its T-bit drive back to back
  always_comb begin
    shift_n = shift;
    cnt_n   = cnt;
    sda_n   = sda;
    oe_n    = oe;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: if (bus.i_tx_en && bus.i_tx_mode != MODE_SERIAL) begin
        sda_n  = tbit_go ? par : 1'b1;
        oe_n   = tbit_go;
        done_n = !tbit_go;
      end
      ST_LOAD: begin
        shift_n = bus.i_regf_data;
        cnt_n   = '0;
        sda_n   = bus.i_regf_data[7];
        oe_n    = 1'b1;
      end
      ST_SERIAL: if (bus.i_scl_neg_edge) begin
        cnt_n   = cnt + 3'd1;
        shift_n = {shift[6:0], 1'b0};
        sda_n   = cnt == 3'd7 ? sda : shift[6];
        done_n  = cnt == 3'd7;
      end
      default: done_n = bus.i_scl_neg_edge;
    endcase
  end
  assign bus.o_sda          = sda;
  assign bus.o_sda_oe       = oe;
  assign bus.o_tx_mode_done = done;
  assign bus.o_busy         = state != ST_IDLE;
endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer: random requests against a receiver-side scoreboard of bits seen on SCL edges and done pulses.
module tb_tx_serializer;
  import tx_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  tx_serializer_if bus ();
  tx_serializer dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  typedef struct {
    int         n;
    logic [7:0] bits;
    logic       sda;
    logic       oe;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, passed = 0;
  logic [7:0] model_last;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction
  // monitor: acts like a bus receiver, sampling SDA at each SCL falling edge while busy
  logic [7:0] cap = '0;
  logic [8:0] m;
  int ncap = 0, last_evt = 0, ncyc = 0;
  always @(negedge clk) begin
    ncyc++;
    if (rst) ncap = 0;
    else begin
      if (bus.o_tx_mode_done) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done at cycle %0d", ncyc);
        end else begin
          e = q.pop_front();
          m = (9'd1 << e.n) - 9'd1;
          chk("done_bits", {24'(ncap), cap & m[7:0]}, {24'(e.n), e.bits});
          chk("done_bus", {30'd0, bus.o_sda_oe, bus.o_sda}, {30'd0, e.oe, e.sda});
          chk("done_latency", ncyc - last_evt, 1);
        end
        ncap = 0;
      end
      if (bus.i_scl_neg_edge && bus.o_busy) begin
        cap = {cap[6:0], bus.o_sda};
        ncap++;
        last_evt = ncyc;
      end
      if (bus.i_tx_en && !bus.o_busy) begin
        ncap = 0;
        last_evt = ncyc;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic gap(int mx);
    repeat ($urandom_range(0, mx)) tick();
  endtask
  task automatic edge_pulse();
    bus.i_scl_neg_edge = 1'b1;
    tick();
    bus.i_scl_neg_edge = 1'b0;
  endtask
  task automatic req(logic [2:0] md);
    bus.i_tx_en = 1'b1;
    bus.i_tx_mode = md;
    tick();
    bus.i_tx_en = 1'b0;
    bus.i_tx_mode = 3'($urandom);
  endtask
  task automatic do_release(logic [2:0] md);
    q.push_back('{0, 8'h00, 1'b1, 1'b0});
    req(md);
  endtask
  task automatic do_byte(logic [7:0] d, bit collide);
    q.push_back('{8, d, d[0], 1'b1});
    model_last = d;
    req(MODE_SERIAL);
    bus.i_regf_data = d;
    tick();
    bus.i_regf_data = 8'($urandom);
    chk("busy_serial", 32'(bus.o_busy), 1);
    for (int i = 0; i < 8; i++) begin
      gap(2);
      if (collide && i == 3) begin
        bus.i_tx_en = 1'b1;
        bus.i_tx_mode = MODE_TBIT;
        tick();
        bus.i_tx_en = 1'b0;
      end
      edge_pulse();
    end
  endtask
  task automatic do_tbit();
`ifdef TX_SERIALIZER_TBIT_EN
    logic p;
    p = ($countones(model_last) % 2) == 0;
    q.push_back('{1, {7'd0, p}, p, 1'b1});
    req(MODE_TBIT);
    gap(2);
    edge_pulse();
`else
    do_release(MODE_TBIT);
`endif
  endtask
  task automatic chk_released(string tag);
    chk({tag, "_sda"}, 32'(bus.o_sda), 1);
    chk({tag, "_oe"}, 32'(bus.o_sda_oe), 0);
    chk({tag, "_done"}, 32'(bus.o_tx_mode_done), 0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
  endtask
  initial begin
    int k;
    bus.i_tx_en = 1'b0;
    bus.i_tx_mode = '0;
    bus.i_regf_data = '0;
    bus.i_scl_neg_edge = 1'b0;
    model_last = '0;
    rst = 1'b1;
    repeat (2) tick();
    chk_released("reset");
    rst = 1'b0;
    tick();
    do_tbit();
    tick();
    do_byte(8'hFC, 1'b0);
    do_tbit();
    tick();
    do_byte(8'h01, 1'b0);
    tick();
    do_tbit();
    do_release(MODE_IDLE_REL);
    tick();
    do_release(3'b111);
    do_byte(8'hA5, 1'b1);
    for (int r = 0; r < 40; r++) begin
      gap(1);
      k = $urandom_range(0, 7);
      if (k == 1) do_byte(8'($urandom), 1'b0);
      else if (k == 3) do_tbit();
      else do_release(3'(k));
    end
    tick();
    req(MODE_SERIAL);
    bus.i_regf_data = 8'h3C;
    tick();
    repeat (3) edge_pulse();
    #2 rst = 1'b1;
    #1 chk_released("abort");
    model_last = '0;
    tick();
    rst = 1'b0;
    repeat (5) edge_pulse();
    do_tbit();
    tick();
    do_byte(8'h5A, 1'b0);
    repeat (4) tick();
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
